// File: rtl/mp_arith_seq.sv
// Multi-precision arithmetic sequencer: runs ADD/ADC/SUB/SBC/INC/DEC/CMP over
//   1..15-byte little-endian operands through a shared 8-bit external adder.
// Latency: DONE in cycle 2*LEN+1 after the START sample (cycle 1 for an
//   illegal request).
// Backpressure: none. START is honoured only in IDLE, and a request made while
//   busy or finishing is dropped.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START, OP, LEN      request handshake from the decoder
//   SRC_A, SRC_B, DST   base (LSB) addresses of operand A, operand B and result
//   RA_ADDR/RB_ADDR     register-file read addresses, RA_DATA/RB_DATA one cycle later
//   WE, WA, WD          register-file write port
//   AS_A, AS_B, AS_CI, AS_ADD, AS_BOP  -> external adder; AS_Y, AS_CO, AS_OVF <- adder
//   BUSY, DONE, ERR     status; ERR is only meaningful while DONE is high
//   C/V/N/Z_FLAG        result flags of the last successful operation
module mp_arith_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [2:0]        OP,
  input  logic [3:0]        LEN,
  input  logic [ADDR_W-1:0] SRC_A,
  input  logic [ADDR_W-1:0] SRC_B,
  input  logic [ADDR_W-1:0] DST,
  output logic [ADDR_W-1:0] RA_ADDR,
  output logic [ADDR_W-1:0] RB_ADDR,
  input  logic [7:0]        RA_DATA,
  input  logic [7:0]        RB_DATA,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [7:0]        WD,
  output logic [7:0]        AS_A,
  output logic [7:0]        AS_B,
  output logic              AS_CI,
  output logic              AS_ADD,
  output logic              AS_BOP,
  input  logic [7:0]        AS_Y,
  input  logic              AS_CO,
  input  logic              AS_OVF,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              C_FLAG,
  output logic              V_FLAG,
  output logic              N_FLAG,
  output logic              Z_FLAG
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // Opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [3:0]        len_q, len_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [3:0]        idx_q, idx_d;
  logic              carry_q, carry_d;   // carry chained between bytes
  logic              zero_q, zero_d;     // all bytes so far were zero
  logic              err_q, err_d;
  logic              c_flag_q, c_flag_d;
  logic              v_flag_q, v_flag_d;
  logic              n_flag_q, n_flag_d;
  logic              z_flag_q, z_flag_d;

  // Per-op adder controls and byte-0 carry-in
  logic ctl_add;
  logic ctl_bop;
  logic ctl_ci0;
  logic carry_in;

  logic              in_fetch;
  logic              in_exec;
  logic              last_byte;
  logic              y_zero;
  logic [ADDR_W-1:0] idx_addr;

  assign in_fetch  = (state_q == S_FETCH);
  assign in_exec   = (state_q == S_EXEC);
  assign last_byte = (idx_q == (len_q - 4'd1));
  assign y_zero    = (AS_Y == 8'h00);
  // Byte index folded into the address space so offsets wrap with the base.
  assign idx_addr  = ADDR_W'(idx_q);

  always_comb begin
    ctl_add = 1'b0;
    ctl_bop = 1'b0;
    ctl_ci0 = 1'b0;
    case (op_q)
      OP_ADD: begin ctl_add = 1'b1; ctl_bop = 1'b1; ctl_ci0 = 1'b0;     end
      OP_ADC: begin ctl_add = 1'b1; ctl_bop = 1'b1; ctl_ci0 = c_flag_q; end
      OP_SUB: begin ctl_add = 1'b0; ctl_bop = 1'b1; ctl_ci0 = 1'b1;     end
      OP_SBC: begin ctl_add = 1'b0; ctl_bop = 1'b1; ctl_ci0 = c_flag_q; end
      // INC/DEC drop operand B: INC adds the carry-in, DEC adds 0xFF.
      OP_INC: begin ctl_add = 1'b1; ctl_bop = 1'b0; ctl_ci0 = 1'b1;     end
      OP_DEC: begin ctl_add = 1'b0; ctl_bop = 1'b0; ctl_ci0 = 1'b0;     end
      OP_CMP: begin ctl_add = 1'b0; ctl_bop = 1'b1; ctl_ci0 = 1'b1;     end
      default: begin ctl_add = 1'b0; ctl_bop = 1'b0; ctl_ci0 = 1'b0;    end
    endcase
  end

  // Only byte 0 takes the op-specific carry-in; higher bytes chain the carry.
  assign carry_in = (idx_q == 4'd0) ? ctl_ci0 : carry_q;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    c_flag_d = c_flag_q;
    v_flag_d = v_flag_q;
    n_flag_d = n_flag_q;
    z_flag_d = z_flag_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = OP;
          len_d   = LEN;
          src_a_d = SRC_A;
          src_b_d = SRC_B;
          dst_d   = DST;
          idx_d   = 4'd0;
          carry_d = 1'b0;
          zero_d  = 1'b1;
          if ((LEN == 4'd0) || (OP == OP_RSV)) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            err_d   = 1'b0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        carry_d = AS_CO;
        zero_d  = zero_q & y_zero;
        if (last_byte) begin
          // Commit the flags on the final byte so they are already valid in
          // the cycle DONE is presented.
          c_flag_d = AS_CO;
          v_flag_d = AS_OVF;
          n_flag_d = AS_Y[7];
          z_flag_d = zero_q & y_zero;
          state_d  = S_FIN;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      len_q    <= 4'd0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      idx_q    <= 4'd0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      c_flag_q <= 1'b0;
      v_flag_q <= 1'b0;
      n_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      c_flag_q <= c_flag_d;
      v_flag_q <= v_flag_d;
      n_flag_q <= n_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  // Read addresses are presented in FETCH; the register file answers during
  // EXEC, which also writes byte i before byte i+1 is fetched.
  assign RA_ADDR = in_fetch ? (src_a_q + idx_addr) : '0;
  assign RB_ADDR = in_fetch ? (src_b_q + idx_addr) : '0;

  assign AS_A   = in_exec ? RA_DATA  : 8'h00;
  assign AS_B   = in_exec ? RB_DATA  : 8'h00;
  assign AS_CI  = in_exec & carry_in;
  assign AS_ADD = in_exec & ctl_add;
  assign AS_BOP = in_exec & ctl_bop;

  assign WE = in_exec & (op_q != OP_CMP);
  assign WA = WE ? (dst_q + idx_addr) : '0;
  assign WD = WE ? AS_Y : 8'h00;

  assign BUSY = in_fetch | in_exec;
  assign DONE = (state_q == S_FIN);
  assign ERR  = DONE & err_q;

  assign C_FLAG = c_flag_q;
  assign V_FLAG = v_flag_q;
  assign N_FLAG = n_flag_q;
  assign Z_FLAG = z_flag_q;

endmodule
